// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared state encoding, Ethernet framing constants and speed helpers for the RGMII TX arbiter.
package rgmii_pkg;
    typedef enum logic [2:0] {IDLE, PRE, DATA, FCS, IFG, DROP} state_t;
    localparam logic [7:0] ETH_PREAMBLE = 8'h55;
    localparam logic [7:0] ETH_SFD = 8'hD5;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB_20E3;
    localparam logic [1:0] SPD_10 = 2'd0;
    localparam logic [1:0] SPD_100 = 2'd1;
    localparam logic [1:0] SPD_1000 = 2'd2;
    function automatic logic [6:0] cpb(input logic [1:0] spd);
        return spd[1] ? 7'd1 : (spd == SPD_100) ? 7'd10 : 7'd100;
    endfunction
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: byte-wide reflected CRC-32 accumulator; only built when RGMII_TX_ARB_FCS_EN is defined.
`ifdef RGMII_TX_ARB_FCS_EN
module eth_crc32_d8 import rgmii_pkg::*; (
    input  logic        clk_125mhz,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);
    logic [31:0] nxt;
    always_comb begin
        nxt = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) nxt = nxt[0] ? (nxt >> 1) ^ 32'hEDB8_8320 : nxt >> 1;
    end
    always_ff @(posedge clk_125mhz or posedge reset)
        if (reset) crc <= CRC32_INIT;
        else if (clear) crc <= CRC32_INIT;
        else if (en) crc <= nxt;
endmodule
`endif

// File: rtl/rgmii_tx_frame_arbiter.sv
// rgmii_tx_frame_arbiter: round-robin frame sequencer (preamble/SFD, payload, IFG) onto one RGMII TX byte stream.
// Define RGMII_TX_ARB_FCS_EN to append a generated CRC-32 FCS after each payload.
module rgmii_tx_frame_arbiter import rgmii_pkg::*; #(
    parameter int NUM_SRC = 4,
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_BYTES = 12
) (
    input  logic                       clk_125mhz,
    input  logic                       reset,
    input  logic                       phy_link_status,
    input  logic [1:0]                 phy_speed_status,
    input  logic [8*NUM_SRC-1:0]       s_axis_tdata,
    input  logic [NUM_SRC-1:0]         s_axis_tvalid,
    input  logic [NUM_SRC-1:0]         s_axis_tlast,
    output logic [NUM_SRC-1:0]         s_axis_tready,
    output logic [7:0]                 tx_axis_rgmii_tdata,
    output logic                       tx_axis_rgmii_tvalid,
    input  logic                       tx_axis_rgmii_tready,
    output logic [$clog2(NUM_SRC)-1:0] grant_idx,
    output logic                       busy,
    output logic                       underrun
);
    localparam int GW = $clog2(NUM_SRC);
    localparam int CW = $clog2(IFG_BYTES * 100 + 1);
`ifdef RGMII_TX_ARB_FCS_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif
    state_t state;
    logic [GW-1:0] rr, pick, nxt_g;
    logic [CW-1:0] cnt, ifg_load;
    logic [7:0] fcs_byte;
    logic tx_hs, go_ifg;
`ifdef RGMII_TX_ARB_FCS_EN
    logic [31:0] crc;
    eth_crc32_d8 u_crc (
        .clk_125mhz(clk_125mhz),
        .reset(reset),
        .clear(state == IDLE),
        .en(state == DATA && tx_hs),
        .data(tx_axis_rgmii_tdata),
        .crc(crc)
    );
    assign fcs_byte = state == FCS ? ~crc[8*cnt[1:0] +: 8] : 8'h00;
`else
    assign fcs_byte = 8'h00;
`endif
    // Later indices are overwritten by earlier ones, so the first requester at/after rr wins.
    always_comb begin
        pick = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (s_axis_tvalid[GW'((int'(rr) + i) % NUM_SRC)]) pick = GW'((int'(rr) + i) % NUM_SRC);
    end
    assign nxt_g = (int'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
    assign ifg_load = CW'(IFG_BYTES) * CW'(cpb(phy_speed_status));
    assign tx_hs = tx_axis_rgmii_tvalid & tx_axis_rgmii_tready;
    assign tx_axis_rgmii_tvalid = phy_link_status &&
        (state == PRE || state == FCS || (state == DATA && s_axis_tvalid[grant_idx]));
    assign tx_axis_rgmii_tdata = state == PRE ? (cnt < CW'(PREAMBLE_LEN) ? ETH_PREAMBLE : ETH_SFD) :
                                 state == DATA ? s_axis_tdata[8*grant_idx +: 8] : fcs_byte;
    assign busy = state != IDLE;
    assign underrun = state == DATA && phy_link_status && tx_axis_rgmii_tready && !s_axis_tvalid[grant_idx];
    assign go_ifg = (state == DATA && phy_link_status && tx_hs && s_axis_tlast[grant_idx] && !FCS_EN) ||
                    (state == FCS && phy_link_status && tx_hs && cnt[1:0] == 2'd3) ||
                    (state == DROP && s_axis_tvalid[grant_idx] && s_axis_tlast[grant_idx]);
    always_comb begin
        s_axis_tready = '0;
        if (state == DATA && phy_link_status) s_axis_tready[grant_idx] = tx_axis_rgmii_tready;
        else if (state == DROP) s_axis_tready[grant_idx] = 1'b1;
    end
    always_ff @(posedge clk_125mhz or posedge reset)
        if (reset) begin
            state <= IDLE;
            grant_idx <= '0;
            rr <= '0;
            cnt <= '0;
        end else if (go_ifg) begin
            state <= IFG;
            cnt <= ifg_load;
            rr <= nxt_g;
        end else begin
            case (state)
                IDLE: if (phy_link_status && |s_axis_tvalid) begin
                    state <= PRE;
                    grant_idx <= pick;
                    cnt <= '0;
                end
                PRE: if (!phy_link_status) state <= DROP;
                    else if (tx_hs) begin
                        state <= cnt == CW'(PREAMBLE_LEN) ? DATA : PRE;
                        cnt <= cnt == CW'(PREAMBLE_LEN) ? '0 : cnt + 1'b1;
                    end
                DATA: if (!phy_link_status) state <= DROP;
                    else if (tx_hs && s_axis_tlast[grant_idx]) begin
                        state <= FCS;
                        cnt <= '0;
                    end
                FCS: if (!phy_link_status) state <= DROP;
                    else if (tx_hs) cnt <= cnt + 1'b1;
                IFG: begin
                    state <= cnt <= CW'(1) ? IDLE : IFG;
                    cnt <= cnt - 1'b1;
                end
                DROP: state <= DROP;
                default: state <= IDLE;
            endcase
        end
endmodule
